// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider_pkg
//  Description : Shared types and helpers for the sequential restoring divider
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

    // Controller states of the divider
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width: ceiling log2 of the operand width
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_cla_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : cla_subtractor
//  Description : Combinational a - b computed as a + ~b + 1 with a parallel
//                -prefix generate/propagate carry network. borrow_n is the
//                carry-out: 1 means a >= b.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_n
);

    localparam int c_LEVELS = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_gk [0:c_LEVELS];
    logic [WIDTH-1:0] w_pk [0:c_LEVELS];
    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;

    // Prefix tree: after the last level w_gk[i] is the carry out of bit i,
    // with the constant carry-in of 1 folded into bit 0 at the base.
    always_comb begin
        w_g0    = a & ~b;
        w_p0    = a ^ ~b;
        w_gk[0] = w_g0;
        w_gk[0][0] = w_g0[0] | w_p0[0];
        w_pk[0] = w_p0;
        for (int k = 1; k <= c_LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (k - 1))) begin
                    w_gk[k][i] = w_gk[k-1][i] | (w_pk[k-1][i] & w_gk[k-1][i - (1 << (k - 1))]);
                    w_pk[k][i] = w_pk[k-1][i] & w_pk[k-1][i - (1 << (k - 1))];
                end else begin
                    w_gk[k][i] = w_gk[k-1][i];
                    w_pk[k][i] = w_pk[k-1][i];
                end
            end
        end
        w_carry  = {w_gk[c_LEVELS][WIDTH-2:0], 1'b1};
        diff     = w_p0 ^ w_carry;
        borrow_n = w_gk[c_LEVELS][WIDTH-1];
    end

    // Final-level group propagates have no consumer
    assign w_unused_p = ^w_pk[c_LEVELS];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                clock, start/busy/done handshake. Trial subtraction via
//                cla_subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    // Partial remainder; its MSB is always 0 between iterations since R < divisor
    logic [WIDTH:0]     r_rem;
    // Dividend shifts out of the top while quotient bits shift in at the bottom
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dbz;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_no_borrow;
    logic               w_unused_msb;

    assign w_shift      = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_unused_msb = r_rem[WIDTH];

    cla_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a        (w_shift),
        .b        ({1'b0, r_dvs}),
        .diff     (w_diff),
        .borrow_n (w_no_borrow)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake outputs and start acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture and one restoring iteration per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dvs <= divisor;
            r_cnt <= c_CNT_LAST;
            if (divisor == '0) begin
                r_dvd <= '1;
                r_rem <= {1'b0, dividend};
                r_dbz <= 1'b1;
            end else begin
                r_dvd <= dividend;
                r_rem <= '0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_rem <= w_no_borrow ? w_diff : w_shift;
            r_dvd <= {r_dvd[WIDTH-2:0], w_no_borrow};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    assign quotient    = r_dvd;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Scoreboard bench for seq_restoring_divider (WIDTH=8)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb [$];
    exp_t         mon_e;
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] last_q   = '0;
    logic [W-1:0] last_r   = '0;
    logic         last_dbz = 1'b0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=done_pulse required=no_done (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient",    quotient,    mon_e.q);
                chk("remainder",   remainder,   mon_e.r);
                chk("div_by_zero", div_by_zero, mon_e.dbz);
                chk("latency",     cyc - mon_e.acc, mon_e.lat);
                last_q   = mon_e.q;
                last_r   = mon_e.r;
                last_dbz = mon_e.dbz;
            end
        end
    end

    // Called at a negedge: present a request, predict its result, retire start
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.dbz    = (b == 0);
        e.q      = (b == 0) ? {W{1'b1}} : a / b;
        e.r      = (b == 0) ? a : a % b;
        e.acc    = cyc + 1;
        e.lat    = (b == 0) ? 0 : W;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Bounded wait for done, counting busy cycles seen on the way
    task automatic wait_done(input int exp_busy, input string tag);
        int n  = 0;
        int nb = 0;
        while (done !== 1'b1 && n < 4 * W + 10) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, 4 * W + 10);
        end
        chk({tag, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   busy,        0);
        chk("rst_done",   done,        0);
        chk("rst_q",      quotient,    0);
        chk("rst_r",      remainder,   0);
        chk("rst_dbz",    div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(8'd100, 8'd7);   wait_done(W, "d100_7");
        @(negedge clk);
        chk("done_single_pulse", done,     0);
        chk("q_held_after_done", quotient, 14);
        issue(8'd255, 8'd1);   wait_done(W, "d255_1");
        issue(8'd5,   8'd10);  wait_done(W, "d5_10");
        issue(8'd0,   8'd3);   wait_done(W, "d0_3");
        @(negedge clk);
        issue(8'd42,  8'd0);   wait_done(0, "dbz");
        @(negedge clk);

        // Starts during RUN are ignored; start in the done cycle is accepted
        issue(8'd200, 8'd9);
        for (int i = 0; i < 3; i++) begin
            start    = 1'b1;
            dividend = 8'd13;
            divisor  = 8'd2;
            chk("busy_during_ignored_start", busy, 1);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(W - 3, "d200_9");
        issue(8'd13, 8'd2);    wait_done(W, "b2b_13_2");
        @(negedge clk);

        // Asynchronous reset mid-operation discards the operation
        issue(8'd250, 8'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy,        0);
        chk("midrst_done", done,        0);
        chk("midrst_q",    quotient,    0);
        chk("midrst_r",    remainder,   0);
        chk("midrst_dbz",  div_by_zero, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'd250, 8'd3);   wait_done(W, "d250_3");

        // Random sweep with random idle gaps (gap 0 gives back-to-back)
        for (int i = 0; i < 1500; i++) begin
            a = W'($urandom);
            if ($urandom_range(0, 15) == 0)      b = '0;
            else if ($urandom_range(0, 3) == 0)  b = W'($urandom_range(1, 15));
            else                                 b = W'($urandom);
            if ($urandom_range(0, 7) == 0 && b != 0) a = W'($urandom_range(0, 31));
            issue(a, b);
            wait_done((b == 0) ? 0 : W, "rand");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rand_hold_q",   quotient,    last_q);
                chk("rand_hold_r",   remainder,   last_r);
                chk("rand_hold_dbz", div_by_zero, last_dbz);
                chk("rand_idle_done", done,       0);
            end
        end

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
